// File: rtl/gpio_seg7_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpio_seg7_ctrl
// Purpose  : Queues processor GPIO writes in a small FIFO and shows each value
//            on eight active-low seven-segment digits for a guaranteed minimum
//            dwell time, so back-to-back writes remain visible.
// Ports    : clk, rst_n (async, active-low)
//            gpio_i[31:0], we_gpio_i          - GPIO write port
//            hex0_o..hex7_o[6:0]              - segments {g,f,e,d,c,b,a}, active-low
//            shown_value_o[31:0]              - value currently displayed
//            busy_o, fifo_full_o, drop_cnt_o  - status
// Options  : SEG7_LEADING_ZERO_BLANK_EN - blank digits above the most
//            significant non-zero nibble (hex0 never blanked).
// Revision : 1.0 - initial release
// ============================================================================
module gpio_seg7_ctrl #(
   parameter int FIFO_DEPTH   = 4,
   parameter int DWELL_CYCLES = 1000,
   parameter int DWELL_W      = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] gpio_i,
   input  logic        we_gpio_i,
   output logic [6:0]  hex0_o,
   output logic [6:0]  hex1_o,
   output logic [6:0]  hex2_o,
   output logic [6:0]  hex3_o,
   output logic [6:0]  hex4_o,
   output logic [6:0]  hex5_o,
   output logic [6:0]  hex6_o,
   output logic [6:0]  hex7_o,
   output logic [31:0] shown_value_o,
   output logic        busy_o,
   output logic        fifo_full_o,
   output logic [7:0]  drop_cnt_o
);

   localparam int               c_AW         = $clog2(FIFO_DEPTH);
   localparam logic [DWELL_W-1:0] c_DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [6:0]       c_SEG_ZERO   = 7'b1000000;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   function automatic logic [6:0] seg7_dec(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0011000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

   // FIFO storage and pointers (extra MSB distinguishes full from empty)
   logic [31:0]        r_mem [FIFO_DEPTH];
   logic [c_AW:0]      r_wr_ptr;
   logic [c_AW:0]      r_rd_ptr;
   state_t             r_state;
   state_t             w_state_next;
   logic [DWELL_W-1:0] r_cnt;
   logic [DWELL_W-1:0] w_cnt_next;
   logic [31:0]        r_shown;
   logic [6:0]         r_hex [8];
   logic [6:0]         w_next_hex [8];
   logic [7:0]         r_drop_cnt;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic [31:0]        w_head;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                    (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
   assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   assign w_push  = we_gpio_i && (!w_full || w_pop);
   assign w_drop  = we_gpio_i && w_full && !w_pop;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_pop        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_cnt_next   = c_DWELL_LOAD;
               w_state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (r_cnt != '0) begin
               w_cnt_next = r_cnt - 1'b1;
            end else if (!w_empty) begin
               w_pop      = 1'b1;
               w_cnt_next = c_DWELL_LOAD;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= gpio_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------- decode
   for (genvar k = 0; k < 8; k++) begin : g_digit
      logic [6:0] w_seg;
      assign w_seg = seg7_dec(w_head[4*k +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (k == 0) begin : g_lsd
         assign w_next_hex[k] = w_seg;
      end else begin : g_msd
         // Blank when this nibble and everything above it is zero.
         assign w_next_hex[k] = (w_head[31:4*k] == '0) ? 7'b1111111 : w_seg;
      end
`else
      assign w_next_hex[k] = w_seg;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shown <= '0;
         for (int i = 0; i < 8; i++) r_hex[i] <= c_SEG_ZERO;
      end else if (w_pop) begin
         r_shown <= w_head;
         for (int i = 0; i < 8; i++) r_hex[i] <= w_next_hex[i];
      end
   end

   assign hex0_o        = r_hex[0];
   assign hex1_o        = r_hex[1];
   assign hex2_o        = r_hex[2];
   assign hex3_o        = r_hex[3];
   assign hex4_o        = r_hex[4];
   assign hex5_o        = r_hex[5];
   assign hex6_o        = r_hex[6];
   assign hex7_o        = r_hex[7];
   assign shown_value_o = r_shown;
   assign busy_o        = (r_state == ST_HOLD) || !w_empty;
   assign fifo_full_o   = w_full;
   assign drop_cnt_o    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gpio_seg7_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_seg7_ctrl
// Purpose  : Directed self-checking bench for gpio_seg7_ctrl
//            (FIFO_DEPTH=4, DWELL_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_seg7_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] gpio_i = '0;
   logic        we_gpio_i = 1'b0;
   logic [6:0]  hex0_o, hex1_o, hex2_o, hex3_o, hex4_o, hex5_o, hex6_o, hex7_o;
   logic [31:0] shown_value_o;
   logic        busy_o;
   logic        fifo_full_o;
   logic [7:0]  drop_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [6:0] c_BLANK = 7'b1111111;
   localparam logic [6:0] c_ZERO  = 7'b1000000;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] c_HI    = c_BLANK;
`else
   localparam logic [6:0] c_HI    = c_ZERO;
`endif

   gpio_seg7_ctrl #(
      .FIFO_DEPTH   (4),
      .DWELL_CYCLES (4),
      .DWELL_W      (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .gpio_i        (gpio_i),
      .we_gpio_i     (we_gpio_i),
      .hex0_o        (hex0_o),
      .hex1_o        (hex1_o),
      .hex2_o        (hex2_o),
      .hex3_o        (hex3_o),
      .hex4_o        (hex4_o),
      .hex5_o        (hex5_o),
      .hex6_o        (hex6_o),
      .hex7_o        (hex7_o),
      .shown_value_o (shown_value_o),
      .busy_o        (busy_o),
      .fifo_full_o   (fifo_full_o),
      .drop_cnt_o    (drop_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one active edge and settle a little after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] burst [3];
   logic [31:0] ovf   [7];

   initial begin
      burst[0] = 32'h0000000A;
      burst[1] = 32'hFFFFFFFF;
      burst[2] = 32'h00C0FFEE;
      for (int k = 0; k < 7; k++) ovf[k] = 32'h100 + k;

      // ---------------- reset
      repeat (3) step();
      check("rst_hex0", hex0_o, c_ZERO);
      check("rst_hex7", hex7_o, c_ZERO);
      check("rst_shown", shown_value_o, 0);
      check("rst_drop", drop_cnt_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_full", fifo_full_o, 0);
      rst_n = 1'b1;
      step();

      // ---------------- single write
      gpio_i = 32'h12345678; we_gpio_i = 1'b1;
      step();
      we_gpio_i = 1'b0;
      check("single_not_bypassed", shown_value_o, 0);
      check("single_busy_queued", busy_o, 1);
      step();
      check("single_shown", shown_value_o, 32'h12345678);
      check("single_hex0", hex0_o, 7'b0000000);
      check("single_hex3", hex3_o, 7'b0010010);
      check("single_hex7", hex7_o, 7'b1111001);
      repeat (3) step();
      check("single_busy_dwell", busy_o, 1);
      step();
      check("single_busy_fall", busy_o, 0);
      check("single_hold_value", shown_value_o, 32'h12345678);

      // ---------------- burst of three
      gpio_i = burst[0]; we_gpio_i = 1'b1;
      step();
      gpio_i = burst[1];
      step();
      check("burst_c0", shown_value_o, burst[0]);
      gpio_i = burst[2];
      step();
      check("burst_c1", shown_value_o, burst[0]);
      we_gpio_i = 1'b0;
      for (int i = 2; i < 12; i++) begin
         step();
         check($sformatf("burst_c%0d", i), shown_value_o, burst[i/4]);
         if (i == 7) check("burst_hex0_F", hex0_o, 7'b0001110);
      end
      check("burst_hex7_hi", hex7_o, c_HI);
      step();
      check("burst_idle", busy_o, 0);

      // ---------------- overflow
      for (int k = 0; k < 7; k++) begin
         gpio_i = ovf[k]; we_gpio_i = 1'b1;
         step();
         if (k >= 1) check($sformatf("ovf_show_%0d", k), shown_value_o, ovf[(k-1)/4]);
         if (k == 4) check("ovf_full_n4", fifo_full_o, 1);
         if (k == 5) check("ovf_drop_n5", drop_cnt_o, 0);
      end
      we_gpio_i = 1'b0;
      check("ovf_drop", drop_cnt_o, 1);
      for (int j = 7; j <= 24; j++) begin
         step();
         check($sformatf("ovf_show_%0d", j), shown_value_o, ovf[(j-1)/4]);
      end
      step();
      check("ovf_end_busy", busy_o, 0);
      check("ovf_end_shown", shown_value_o, ovf[5]);

      // ---------------- reset mid-HOLD with two entries queued
      gpio_i = 32'hAAAA0001; we_gpio_i = 1'b1;
      step();
      gpio_i = 32'hAAAA0002;
      step();
      gpio_i = 32'hAAAA0003;
      step();
      we_gpio_i = 1'b0;
      check("mid_shown", shown_value_o, 32'hAAAA0001);
      rst_n = 1'b0;
      #2;
      check("mrst_shown", shown_value_o, 0);
      check("mrst_hex0", hex0_o, c_ZERO);
      check("mrst_hex4", hex4_o, c_ZERO);
      check("mrst_busy", busy_o, 0);
      check("mrst_drop", drop_cnt_o, 0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("mrst_quiet_%0d", i), shown_value_o, 0);
      end
      check("mrst_quiet_busy", busy_o, 0);

      // ---------------- blanking
      gpio_i = 32'h000000A5; we_gpio_i = 1'b1;
      step();
      we_gpio_i = 1'b0;
      step();
      check("blk_hex0", hex0_o, 7'b0010010);
      check("blk_hex1", hex1_o, 7'b0001000);
      check("blk_hex2", hex2_o, c_HI);
      check("blk_hex7", hex7_o, c_HI);
      repeat (4) step();
      gpio_i = 32'h00F0000A; we_gpio_i = 1'b1;
      step();
      we_gpio_i = 1'b0;
      step();
      check("blk2_hex1_inner", hex1_o, c_ZERO);
      check("blk2_hex4", hex4_o, 7'b1000000);
      check("blk2_hex5", hex5_o, 7'b0001110);
      check("blk2_hex6", hex6_o, c_HI);
      repeat (4) step();
      gpio_i = 32'h00000000; we_gpio_i = 1'b1;
      step();
      we_gpio_i = 1'b0;
      step();
      check("blk3_hex0", hex0_o, c_ZERO);
      check("blk3_hex1", hex1_o, c_HI);
      repeat (5) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
